// File: rtl/dogx_output_serializer.sv
// dogx_output_serializer
// Boxcar decimator (accumulate-and-dump over 2^DEC_LOG2 samples) feeding a
// small word FIFO, followed by a 16-bit MSB-first serial framer with frame
// sync and a CLK_24M/2 bit clock.
// Optional build macro: DOGX_SER_PARITY_EN -- frame bit 15 carries even parity
// over frame bits [14:0] instead of the sign extension.
module dogx_output_serializer #(
  parameter int DEC_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_24M,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [10:0] converter_output,
  output logic        SCK_OUT,
  output logic        SDO,
  output logic        FS,
  output logic        fifo_overflow
);

  localparam int ACC_W = 11 + DEC_LOG2;
  localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // With DEC_LOG2 = 0 the counter is a single bit pinned at 0, so every
  // accepted sample is a dump.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Decimator
  logic signed [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    accept;
  logic                    dump;
  logic [15:0]             push_word;

  // FIFO
  logic [15:0]    mem_reg [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_reg;
  logic [PTR_W:0] rd_ptr_reg;
  logic           fifo_empty;
  logic           fifo_full;
  logic           fifo_avail;
  logic           push;
  logic           pop;
  logic [15:0]    head_word;
  logic [15:0]    load_word;
  logic           overflow_reg;

  // Serializer
  state_t      state_reg, state_next;
  logic        ph_reg, ph_next;
  logic [3:0]  bitcnt_reg, bitcnt_next;
  logic [15:0] sr_reg, sr_next;
  logic        sck_reg, sdo_reg, fs_reg;

  assign sample_ext = ACC_W'($signed(converter_output));
  assign sum        = acc_reg + sample_ext;
  assign accept     = sample_valid && enable;
  assign dump       = accept && (cnt_reg == CNT_LAST);
  assign push_word  = 16'(sum);

  // Accumulate-and-dump; enable low discards any partial sum.
  always_ff @(posedge CLK_24M) begin
    if (!reset_n || !enable) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (sample_valid) begin
      if (cnt_reg == CNT_LAST) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= sum;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  // Gating with enable keeps queued words from being launched while they are
  // being flushed.
  assign fifo_avail = enable && !fifo_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push       = dump && (!fifo_full || pop);
  assign head_word  = mem_reg[rd_ptr_reg[PTR_W-1:0]];

`ifdef DOGX_SER_PARITY_EN
  assign load_word = {^head_word[14:0], head_word[14:0]};
`else
  assign load_word = head_word;
`endif

  // FIFO storage write port.
  always_ff @(posedge CLK_24M) begin
    if (push) begin
      mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_word;
    end
  end

  // FIFO pointers; enable low empties the FIFO every cycle.
  always_ff @(posedge CLK_24M) begin
    if (!reset_n || !enable) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

  // Sticky drop flag, cleared by reset or enable low.
  always_ff @(posedge CLK_24M) begin
    if (!reset_n || !enable) begin
      overflow_reg <= 1'b0;
    end else if (dump && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  // Serializer state, shift register and output flops.
  always_ff @(posedge CLK_24M) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ph_reg     <= 1'b0;
      bitcnt_reg <= 4'd0;
      sr_reg     <= 16'd0;
      sck_reg    <= 1'b0;
      sdo_reg    <= 1'b0;
      fs_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ph_reg     <= ph_next;
      bitcnt_reg <= bitcnt_next;
      sr_reg     <= sr_next;
      // Outputs are computed from the next state so the pins are pure flops.
      sck_reg    <= (state_next == SHIFT) && ph_next;
      sdo_reg    <= (state_next == SHIFT) && sr_next[15];
      fs_reg     <= (state_next == SHIFT) && (bitcnt_next == 4'd15);
    end
  end

  // Next-state logic: load/pop on IDLE or last bit, shift after each SCK high.
  always_comb begin
    state_next  = state_reg;
    ph_next     = ph_reg;
    bitcnt_next = bitcnt_reg;
    sr_next     = sr_reg;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_avail) begin
          pop         = 1'b1;
          sr_next     = load_word;
          ph_next     = 1'b0;
          bitcnt_next = 4'd15;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (!ph_reg) begin
          ph_next = 1'b1;
        end else if (bitcnt_reg == 4'd0) begin
          ph_next = 1'b0;
          if (fifo_avail) begin
            pop         = 1'b1;
            sr_next     = load_word;
            bitcnt_next = 4'd15;
          end else begin
            state_next = IDLE;
          end
        end else begin
          ph_next     = 1'b0;
          sr_next     = {sr_reg[14:0], 1'b0};
          bitcnt_next = bitcnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign SCK_OUT       = sck_reg;
  assign SDO           = sdo_reg;
  assign FS            = fs_reg;
  assign fifo_overflow = overflow_reg;

endmodule

// File: tb/tb_dogx_output_serializer.sv
// Self-checking bench for dogx_output_serializer (default parameters, R=4,
// FIFO depth 4). A receiver monitor rebuilds frames from SCK_OUT/SDO/FS;
// expected words are queued as stimulus is driven and compared per frame.
module tb_dogx_output_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [10:0] converter_output = 11'd0;
  logic        SCK_OUT, SDO, FS, fifo_overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          fslen_q[$];
  int          start_q[$];
  int          strobe4_q[$];
  int          rise_cnt = 0;

  int m_acc = 0;
  int m_cnt = 0;

  dogx_output_serializer #(.DEC_LOG2(2), .FIFO_DEPTH(4)) dut (
    .CLK_24M          (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .converter_output (converter_output),
    .SCK_OUT          (SCK_OUT),
    .SDO              (SDO),
    .FS               (FS),
    .fifo_overflow    (fifo_overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Receiver: data is taken on SCK_OUT rising, frame opened by FS.
  initial begin
    logic        prev_sck;
    logic        in_frame;
    logic [15:0] shreg;
    int          nbits;
    int          fs_len;
    int          start_cyc;
    prev_sck = 1'b0; in_frame = 1'b0; shreg = 16'd0;
    nbits = 0; fs_len = 0; start_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 1'b0;
        nbits    = 0;
      end else begin
        if (SCK_OUT && !prev_sck) rise_cnt = rise_cnt + 1;
        if (FS && !in_frame) begin
          in_frame  = 1'b1;
          nbits     = 0;
          fs_len    = 0;
          start_cyc = cyc;
        end
        if (in_frame) begin
          if (FS) fs_len = fs_len + 1;
          if (SCK_OUT && !prev_sck) begin
            shreg = {shreg[14:0], SDO};
            nbits = nbits + 1;
            if (nbits == 16) begin
              got_q.push_back(shreg);
              fslen_q.push_back(fs_len);
              start_q.push_back(start_cyc);
              in_frame = 1'b0;
            end
          end
        end
      end
      prev_sck = SCK_OUT;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] frame_of(input int s);
    logic [15:0] w;
    w = 16'(s);
`ifdef DOGX_SER_PARITY_EN
    w[15] = ^w[14:0];
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe followed by gap-1 idle cycles; updates the reference sum.
  task automatic send_sample(input int v, input int gap);
    sample_valid     = 1'b1;
    converter_output = 11'(v);
    if (enable && reset_n) begin
      m_acc = m_acc + v;
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) begin
        exp_q.push_back(frame_of(m_acc));
        strobe4_q.push_back(cyc);
        m_acc = 0;
        m_cnt = 0;
      end
    end
    tick();
    sample_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (got_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); fslen_q.delete();
    start_q.delete(); strobe4_q.delete();
    m_acc = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; sample_valid = 1'b0;
    repeat (3) tick();
    checks++; if (SCK_OUT !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", SCK_OUT); end
    checks++; if (SDO !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", SDO); end
    checks++; if (FS !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", FS); end
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", fifo_overflow); end
    reset_n = 1'b1;
    clear_model();
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    logic [15:0] w, want;
`ifdef DOGX_SER_PARITY_EN
    want = 16'h8190;
`else
    want = 16'h0190;
`endif
    clear_model();
    for (int i = 0; i < 4; i++) send_sample(100, 8);
    wait_frames(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d frames want 1", got_q.size()); end
    while (got_q.size() > 0) begin
      w = got_q.pop_front();
      $display("basic frame %04h", w);
      checks++; if (w !== want) begin errors++; $display("FAIL basic_word: got %04h want %04h", w, want); end
      checks++; if (exp_q.size() == 0 || w !== exp_q[0]) begin errors++; $display("FAIL basic_sb: got %04h want queued word", w); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checks++; if (fslen_q[0] !== 2) begin errors++; $display("FAIL basic_fs_len: got %0d want 2", fslen_q[0]); end
      void'(fslen_q.pop_front());
      checks++; if (start_q[0] - strobe4_q[0] !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", start_q[0] - strobe4_q[0]); end
      void'(start_q.pop_front()); void'(strobe4_q.pop_front());
    end
    repeat (8) tick();
  endtask

  task automatic test_extremes();
    bit ok;
    logic [15:0] w, want;
    int vals[3];
    int consts[3];
    vals   = '{-1, 1023, -1024};
    consts = '{32'h0000FFFC, 32'h00000FFC, 32'h0000F000};
    clear_model();
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 4; i++) send_sample(vals[g], 8);
    wait_frames(3, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL extreme_timeout: got %0d frames want 3", got_q.size()); end
    for (int g = 0; g < 3 && got_q.size() > 0; g++) begin
      w = got_q.pop_front();
      want = frame_of(consts[g]);
      $display("extreme frame %0d %04h", g, w);
      checks++; if (w !== want) begin errors++; $display("FAIL extreme_word%0d: got %04h want %04h", g, w, want); end
      checks++; if (exp_q.size() == 0 || w !== exp_q.pop_front()) begin errors++; $display("FAIL extreme_sb%0d: got %04h want %04h", g, w, want); end
    end
    repeat (8) tick();
  endtask

  task automatic test_sustained();
    bit ok;
    logic [15:0] w, e;
    int prev_start;
    clear_model();
    rise_cnt = 0;
    for (int i = 0; i < 24; i++) send_sample(-300 + 25 * i, 8);
    wait_frames(6, 200, ok);
    repeat (4) tick();
    checks++; if (!ok) begin errors++; $display("FAIL sustain_timeout: got %0d frames want 6", got_q.size()); end
    checks++; if (rise_cnt !== 96) begin errors++; $display("FAIL sustain_rises: got %0d want 96", rise_cnt); end
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL sustain_ovf: got %b want 0", fifo_overflow); end
    prev_start = -1;
    for (int k = 0; k < 6 && got_q.size() > 0; k++) begin
      w = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~w;
      $display("sustain frame %0d %04h", k, w);
      checks++; if (w !== e) begin errors++; $display("FAIL sustain_word%0d: got %04h want %04h", k, w, e); end
      checks++; if (start_q[0] - strobe4_q[0] !== 2) begin errors++; $display("FAIL sustain_latency%0d: got %0d want 2", k, start_q[0] - strobe4_q[0]); end
      if (prev_start >= 0) begin
        checks++; if (start_q[0] - prev_start !== 32) begin errors++; $display("FAIL sustain_gap%0d: got %0d want 32", k, start_q[0] - prev_start); end
      end
      prev_start = start_q.pop_front();
      void'(strobe4_q.pop_front());
    end
    repeat (8) tick();
  endtask

  task automatic test_overflow();
    bit ok;
    int n;
    logic [15:0] w, want;
    clear_model();
    want = frame_of(2732);
    sample_valid = 1'b1;
    converter_output = 11'd683;
    repeat (64) tick();
    sample_valid = 1'b0;
    checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", fifo_overflow); end
    wait_frames(6, 300, ok);
    repeat (40) tick();
    n = got_q.size();
    checks++; if (n < 5 || n > 7) begin errors++; $display("FAIL ovf_count: got %0d frames want 5..7", n); end
    while (got_q.size() > 0) begin
      w = got_q.pop_front();
      $display("overflow frame %04h", w);
      checks++; if (w !== want) begin errors++; $display("FAIL ovf_word: got %04h want %04h", w, want); end
    end
    checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", fifo_overflow); end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", fifo_overflow); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int target;
    logic [15:0] w, e;
    clear_model();
    for (int i = 0; i < 4; i++) send_sample(7, 1);
    for (int i = 0; i < 4; i++) send_sample(8, 1);
    target = strobe4_q[0] + 2 + 16;   // bit 7, SCK low phase
    while (cyc < target) tick();
    reset_n = 1'b0;
    tick();
    checks++; if ({SCK_OUT, SDO, FS} !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got %b want 000", {SCK_OUT, SDO, FS}); end
    reset_n = 1'b1;
    clear_model();
    repeat (80) tick();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rst_mid_fifo_empty: got %0d frames want 0", got_q.size()); end
    got_q.delete();
    for (int i = 0; i < 4; i++) send_sample(9, 8);
    wait_frames(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got %0d frames want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      e = frame_of(36);
      $display("post-reset frame %04h", w);
      checks++; if (w !== e) begin errors++; $display("FAIL rst_mid_word: got %04h want %04h", w, e); end
    end
    repeat (8) tick();
  endtask

  task automatic test_enable_mid_frame();
    bit ok;
    int target;
    logic [15:0] w, e;
    clear_model();
    for (int i = 0; i < 4; i++) send_sample(10, 1);
    for (int i = 0; i < 4; i++) send_sample(20, 1);
    for (int i = 0; i < 4; i++) send_sample(30, 1);
    for (int i = 0; i < 2; i++) send_sample(50, 1);
    target = strobe4_q[0] + 2 + 15;
    while (cyc < target) tick();
    enable = 1'b0;
    send_sample(999, 1);
    repeat (2) tick();
    enable = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    m_acc = 0; m_cnt = 0;
    repeat (100) tick();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL en_mid_count: got %0d frames want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      e = frame_of(40);
      $display("enable-drop frame %04h", w);
      checks++; if (w !== e) begin errors++; $display("FAIL en_mid_word: got %04h want %04h", w, e); end
    end
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) send_sample(5, 8);
    wait_frames(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_after_timeout: got %0d frames want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~w;
      $display("post-enable frame %04h", w);
      checks++; if (w !== frame_of(20) || w !== e) begin errors++; $display("FAIL en_after_word: got %04h want %04h", w, frame_of(20)); end
    end
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_sustained();
    test_overflow();
    test_reset_mid_frame();
    test_enable_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dogx_output_serializer.md
# dogx_output_serializer

Downstream stage of the DOGX converter top. Takes the 11-bit two's-complement `converter_output` words, decimates them by boxcar accumulate-and-dump, and buffers the results in a small FIFO. It then streams each result off-chip as a 16-bit MSB-first serial frame with frame sync and a bit clock derived from `CLK_24M`. It is the last digital stage before the pads.

## Interface

Parameters:
- `DEC_LOG2`, default 2: decimation ratio R = 2^DEC_LOG2; legal range 0..4.
- `FIFO_DEPTH`, default 4: decimated-word FIFO depth; must be a power of two, ≥2.

Ports:
- `CLK_24M`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `enable`  in  1  block enable; low = flush datapath.
- `sample_valid`  in  1  one-cycle strobe, `converter_output` valid.
- `converter_output`  in  11  signed converter sample.
- `SCK_OUT`  out  1  serial bit clock, CLK_24M/2 while shifting.
- `SDO`  out  1  serial data, MSB first.
- `FS`  out  1  frame sync, high during bit 15 of each frame.
- `fifo_overflow`  out  1  sticky, a decimated word was dropped.

## Operation

- **Decimator**
  - `acc` is 11+DEC_LOG2 bits, signed. `cnt` is DEC_LOG2 bits.
  - On `sample_valid && enable`:
    - If `cnt != R-1`: `acc += sext(converter_output)` and `cnt++`.
    - Otherwise: push `acc + sext(converter_output)` into the FIFO, clear `acc` and `cnt`.
  - When R=1, every accepted sample is pushed directly.
  - Frame word = sum sign-extended to 16 bits. No saturation; the width cannot overflow for DEC_LOG2 ≤ 4.
- **FIFO**
  - Read data is combinational from the head entry.
  - A push while full drops the word and sets `fifo_overflow`.
  - Push and pop in the same cycle while full is allowed: the pop frees the slot and no drop occurs.
- **Serializer FSM**
  - States: IDLE, SHIFT. Internal signals: phase bit `ph`, 4-bit `bitcnt`, 16-bit shift register `sr`.
  - IDLE with FIFO non-empty: load `sr` from the head, pop, then go to SHIFT with `ph`=0 and `bitcnt`=15.
  - SHIFT, `ph`=0: `SCK_OUT`=0, `SDO`=`sr[15]`, `FS`=(`bitcnt`==15).
  - SHIFT, `ph`=1: `SCK_OUT`=1, and `SDO` and `FS` hold. At the end of this cycle, shift `sr` left and decrement `bitcnt`.
  - Last bit (`bitcnt`==0, `ph`=1):
    - FIFO non-empty: load and pop in the same cycle, stay in SHIFT. Frames are back-to-back with no gap.
    - FIFO empty: go to IDLE.
  - IDLE outputs: `SCK_OUT`=0, `SDO`=0, `FS`=0.
- **Enable low**
  - Clears `acc`, `cnt`, and the FIFO pointers each cycle.
  - Samples are ignored.
  - A frame already in SHIFT completes, then the FSM goes to IDLE.
  - `fifo_overflow` is cleared.

## Timing

- All outputs and state are registered. `SDO`, `SCK_OUT` and `FS` come directly from flops.
- **Reset:** while `reset_n` is low at a clock edge, the next cycle has all outputs 0, state IDLE, and `acc`, `cnt`, FIFO and `fifo_overflow` all 0. Reset mid-frame aborts the frame immediately.
- **Latency:** the R-th `sample_valid` in cycle t gives a FIFO write at the edge ending t.
  - FSM idle: load at the edge ending t+1.
  - `SDO` bit 15 and `FS`=1 in cycle t+2.
  - First `SCK_OUT` rise in cycle t+3.
- **Frame length:** 32 cycles. A receiver samples on the `SCK_OUT` rising edge; data changes only when `SCK_OUT` falls.
- **Throughput:** at the nominal 3 MHz sample strobe (every 8 cycles) with R=4, input and output rates balance exactly. The FIFO absorbs jitter of up to FIFO_DEPTH words.

## Configuration

- Macro `DOGX_SER_PARITY_EN`:
  - **Defined:** frame bit 15 is replaced by even parity over frame bits [14:0], so the 16-bit frame has an even number of ones. Bits [14:0] are unchanged. Frame length and timing are unchanged.
  - **Undefined:** bit 15 is the sign extension.

## Test plan

- **Basic frame:** R=4, `converter_output`=100 on four strobes spaced 8 cycles apart.
  - Without macro: one frame 0x0190.
  - With macro: one frame 0x8190.
  - `FS` is high only for the first 2 cycles of the frame.
- **Negative and extreme sums:**
  - Four samples of -1 → frame 0xFFFC.
  - Four samples of 1023 → 0x0FFC.
  - Four samples of -1024 → 0xF000.
- **Sustained rate:** continuous strobes every 8 cycles with a ramp.
  - Frames are back-to-back, and `SCK_OUT` has 16 rises per 32 cycles with no gaps.
  - `fifo_overflow` stays 0.
  - Latency from the 4th strobe to the first `FS` is 2 cycles.
- **Overflow:** `sample_valid` held high for 64 cycles.
  - `fifo_overflow` rises and stays set.
  - Emitted frames are whole, with no corrupt bits.
  - `enable` pulsed low clears the flag.
- **Reset mid-frame:** assert `reset_n`=0 during bit 7.
  - Next cycle: `SCK_OUT`/`SDO`/`FS`=0 and the FIFO is empty.
  - After release, a fresh 4-sample group produces a correct frame.
- **Enable low mid-frame:** the current frame completes all 16 bits, then the block idles. Queued words and the partial accumulator are discarded.
